// File: rtl/decode_ctrl_pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decode_pkg : encodings, control bundle and FSM states shared by decode_ctrl_pipe
// Revision   : 1.0
// ---------------------------------------------------------------------------
package decode_pkg;

    localparam logic [3:0] ALU_OPCODE_ADD   = 4'd0;
    localparam logic [3:0] ALU_OPCODE_SUB   = 4'd1;
    localparam logic [3:0] ALU_OPCODE_AND   = 4'd2;
    localparam logic [3:0] ALU_OPCODE_OR    = 4'd3;
    localparam logic [3:0] ALU_OPCODE_XOR   = 4'd4;
    localparam logic [3:0] ALU_OPCODE_SLL   = 4'd5;
    localparam logic [3:0] ALU_OPCODE_SRL   = 4'd6;
    localparam logic [3:0] ALU_OPCODE_SRA   = 4'd7;
    localparam logic [3:0] ALU_OPCODE_SLT   = 4'd8;
    localparam logic [3:0] ALU_OPCODE_SLTU  = 4'd9;
    localparam logic [3:0] ALU_OPCODE_PASSB = 4'd10;

    // Branch codes test the ALU result: EQ/NE on zero, LT/GE on bit 0 of SLT/SLTU.
    localparam logic [2:0] PC_NEXT = 3'd0;
    localparam logic [2:0] PC_JAL  = 3'd1;
    localparam logic [2:0] PC_JALR = 3'd2;
    localparam logic [2:0] PC_BEQ  = 3'd3;
    localparam logic [2:0] PC_BNE  = 3'd4;
    localparam logic [2:0] PC_BLT  = 3'd5;
    localparam logic [2:0] PC_BGE  = 3'd6;

    localparam logic [2:0] SIGN_EXTEND_I = 3'd0;
    localparam logic [2:0] SIGN_EXTEND_S = 3'd1;
    localparam logic [2:0] SIGN_EXTEND_B = 3'd2;
    localparam logic [2:0] SIGN_EXTEND_U = 3'd3;
    localparam logic [2:0] SIGN_EXTEND_J = 3'd4;

    localparam logic [1:0] RESULT_ALU   = 2'd0;
    localparam logic [1:0] RESULT_MEM   = 2'd1;
    localparam logic [1:0] RESULT_PC4   = 2'd2;
    localparam logic [1:0] RESULT_PCIMM = 2'd3;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       alu_src;
        logic [3:0] alu_ctrl;
        logic [2:0] pc_src;
        logic [1:0] result_src;
        logic       muldiv;
        logic [2:0] muldiv_op;
        logic [4:0] rd;
    } ctrl_bundle_t;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } muldiv_state_t;

    function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3);
        logic [3:0] op;
        case (funct3)
            3'd0:    op = ALU_OPCODE_ADD;
            3'd1:    op = ALU_OPCODE_SLL;
            3'd2:    op = ALU_OPCODE_SLT;
            3'd3:    op = ALU_OPCODE_SLTU;
            3'd4:    op = ALU_OPCODE_XOR;
            3'd5:    op = ALU_OPCODE_SRL;
            3'd6:    op = ALU_OPCODE_OR;
            default: op = ALU_OPCODE_AND;
        endcase
        return op;
    endfunction

    function automatic ctrl_bundle_t bubble_bundle();
        ctrl_bundle_t b;
        b          = '0;
        b.pc_src   = PC_NEXT;
        b.alu_ctrl = ALU_OPCODE_ADD;
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_comb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decode_comb : pure RV32I(+M) decode table, instr -> control bundle.
// Optional    : DECODE_CTRL_PIPE_MULDIV_EN accepts funct7=0x01 R-type as M ops.
// Revision    : 1.0
// ---------------------------------------------------------------------------
module decode_comb
    import decode_pkg::*;
(
    input  logic [31:0]  instr,
    output ctrl_bundle_t ctrl,
    output logic [2:0]   imm_src,
    output logic         illegal,
    output logic         uses_rs1,
    output logic         uses_rs2,
    output logic [4:0]   rs1,
    output logic [4:0]   rs2
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [4:0] w_rd;

    assign w_opcode = instr[6:0];
    assign w_rd     = instr[11:7];
    assign w_funct3 = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign w_funct7 = instr[31:25];

    always_comb begin
        ctrl       = bubble_bundle();
        ctrl.valid = 1'b1;
        imm_src    = SIGN_EXTEND_I;
        illegal    = 1'b0;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.rd        = w_rd;
                case (w_funct7)
                    7'h00: ctrl.alu_ctrl = alu_from_funct3(w_funct3);
                    7'h20: begin
                        if (w_funct3 == 3'd0)      ctrl.alu_ctrl = ALU_OPCODE_SUB;
                        else if (w_funct3 == 3'd5) ctrl.alu_ctrl = ALU_OPCODE_SRA;
                        else                       illegal = 1'b1;
                    end
`ifdef DECODE_CTRL_PIPE_MULDIV_EN
                    7'h01: begin
                        ctrl.muldiv    = 1'b1;
                        ctrl.muldiv_op = w_funct3;
                    end
`endif
                    default: illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                uses_rs1       = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.rd        = w_rd;
                case (w_funct3)
                    3'd1: begin
                        if (w_funct7 == 7'h00) ctrl.alu_ctrl = ALU_OPCODE_SLL;
                        else                   illegal = 1'b1;
                    end
                    3'd5: begin
                        if (w_funct7 == 7'h00)      ctrl.alu_ctrl = ALU_OPCODE_SRL;
                        else if (w_funct7 == 7'h20) ctrl.alu_ctrl = ALU_OPCODE_SRA;
                        else                        illegal = 1'b1;
                    end
                    default: ctrl.alu_ctrl = alu_from_funct3(w_funct3);
                endcase
            end
            OPC_LOAD: begin
                uses_rs1        = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RESULT_MEM;
                ctrl.rd         = w_rd;
                case (w_funct3)
                    3'd0, 3'd1, 3'd2, 3'd4, 3'd5: ;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_src        = SIGN_EXTEND_S;
                if (w_funct3 > 3'd2) illegal = 1'b1;
            end
            OPC_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm_src  = SIGN_EXTEND_B;
                case (w_funct3)
                    3'd0: begin ctrl.alu_ctrl = ALU_OPCODE_SUB;  ctrl.pc_src = PC_BEQ; end
                    3'd1: begin ctrl.alu_ctrl = ALU_OPCODE_SUB;  ctrl.pc_src = PC_BNE; end
                    3'd4: begin ctrl.alu_ctrl = ALU_OPCODE_SLT;  ctrl.pc_src = PC_BLT; end
                    3'd5: begin ctrl.alu_ctrl = ALU_OPCODE_SLT;  ctrl.pc_src = PC_BGE; end
                    3'd6: begin ctrl.alu_ctrl = ALU_OPCODE_SLTU; ctrl.pc_src = PC_BLT; end
                    3'd7: begin ctrl.alu_ctrl = ALU_OPCODE_SLTU; ctrl.pc_src = PC_BGE; end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.pc_src     = PC_JAL;
                ctrl.result_src = RESULT_PC4;
                ctrl.rd         = w_rd;
                imm_src         = SIGN_EXTEND_J;
            end
            OPC_JALR: begin
                uses_rs1        = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.pc_src     = PC_JALR;
                ctrl.result_src = RESULT_PC4;
                ctrl.rd         = w_rd;
                if (w_funct3 != 3'd0) illegal = 1'b1;
            end
            OPC_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = ALU_OPCODE_PASSB;
                ctrl.rd        = w_rd;
                imm_src        = SIGN_EXTEND_U;
            end
            OPC_AUIPC: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RESULT_PCIMM;
                ctrl.rd         = w_rd;
                imm_src         = SIGN_EXTEND_U;
            end
            // ecall/ebreak travel as a side-effect-free valid slot.
            OPC_SYSTEM: begin
                if (w_funct3 != 3'd0) illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            ctrl     = bubble_bundle();
            imm_src  = SIGN_EXTEND_I;
            uses_rs1 = 1'b0;
            uses_rs2 = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode_ctrl_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decode_ctrl_pipe : registered RV32I decode, ID/EX control register, load-use
//                    and mul/div stall. Optional: DECODE_CTRL_PIPE_MULDIV_EN.
// Revision         : 1.0
// ---------------------------------------------------------------------------
module decode_ctrl_pipe #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MULDIV_LATENCY = 4,
    parameter int ILL_CNT_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_WIDTH-1:0]     instr,
    input  logic                      validD,
    input  logic                      flush,
    input  logic                      ext_stall,
    output logic [2:0]                ImmSrcD,
    output logic                      stallD,
    output logic                      validE,
    output logic                      RegWriteE,
    output logic                      MemWriteE,
    output logic                      MemReadE,
    output logic                      ALUsrcE,
    output logic [3:0]                ALUctrlE,
    output logic [2:0]                PCsrcE,
    output logic [1:0]                ResultSrcE,
    output logic [REG_ADDR_WIDTH-1:0] rdE,
    output logic                      MulDivE,
    output logic [2:0]                MulDivOpE,
    output logic                      illegalD,
    output logic [ILL_CNT_WIDTH-1:0]  ill_count
);
    import decode_pkg::*;

    ctrl_bundle_t             w_dec;
    ctrl_bundle_t             r_e;
    logic                     w_dec_illegal;
    logic                     w_uses_rs1;
    logic                     w_uses_rs2;
    logic [4:0]               w_rs1;
    logic [4:0]               w_rs2;
    logic                     w_load_use;
    logic                     w_muldiv_busy;
    logic                     w_count_ill;
    logic [ILL_CNT_WIDTH-1:0] r_ill_count;

    decode_comb u_decode_comb (
        .instr    (instr),
        .ctrl     (w_dec),
        .imm_src  (ImmSrcD),
        .illegal  (w_dec_illegal),
        .uses_rs1 (w_uses_rs1),
        .uses_rs2 (w_uses_rs2),
        .rs1      (w_rs1),
        .rs2      (w_rs2)
    );

    assign w_load_use = r_e.valid && r_e.mem_read && (r_e.rd != 5'd0) && validD &&
                        ((w_uses_rs1 && (w_rs1 == r_e.rd)) || (w_uses_rs2 && (w_rs2 == r_e.rd)));

    assign stallD   = !flush && (w_load_use || w_muldiv_busy);
    assign illegalD = validD && w_dec_illegal;

`ifdef DECODE_CTRL_PIPE_MULDIV_EN
    localparam int              CNT_W      = (MULDIV_LATENCY > 1) ? $clog2(MULDIV_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MULDIV_LATENCY - 1);

    muldiv_state_t    r_md_state;
    muldiv_state_t    w_md_state_nxt;
    logic [CNT_W-1:0] r_md_cnt;
    logic [CNT_W-1:0] w_md_cnt_nxt;
    logic             w_m_in_d;

    assign w_m_in_d = validD && w_dec.muldiv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_md_state <= MD_IDLE;
            r_md_cnt   <= CNT_RELOAD;
        end else begin
            r_md_state <= w_md_state_nxt;
            r_md_cnt   <= w_md_cnt_nxt;
        end
    end

    // The first D cycle of an M op already stalls; BUSY adds LATENCY-1 more.
    always_comb begin
        w_md_state_nxt = r_md_state;
        w_md_cnt_nxt   = r_md_cnt;
        w_muldiv_busy  = 1'b0;
        case (r_md_state)
            MD_IDLE: begin
                w_muldiv_busy = w_m_in_d;
                if (w_m_in_d && !ext_stall) begin
                    w_md_state_nxt = MD_BUSY;
                    w_md_cnt_nxt   = CNT_RELOAD;
                end
            end
            MD_BUSY: begin
                w_muldiv_busy = (r_md_cnt != '0);
                if (!ext_stall) begin
                    if (r_md_cnt == '0) w_md_state_nxt = MD_IDLE;
                    else                w_md_cnt_nxt   = r_md_cnt - CNT_W'(1);
                end
            end
            default: w_md_state_nxt = MD_IDLE;
        endcase
        if (flush) begin
            w_md_state_nxt = MD_IDLE;
            w_md_cnt_nxt   = CNT_RELOAD;
        end
    end
`else
    assign w_muldiv_busy = 1'b0;
`endif

    assign w_count_ill = illegalD && !stallD && !ext_stall && !flush && !(&r_ill_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e         <= bubble_bundle();
            r_ill_count <= '0;
        end else begin
            if (flush) begin
                r_e <= bubble_bundle();
            end else if (!ext_stall) begin
                if (stallD || !validD) r_e <= bubble_bundle();
                else                   r_e <= w_dec;
            end
            if (w_count_ill) r_ill_count <= r_ill_count + ILL_CNT_WIDTH'(1);
        end
    end

    assign validE     = r_e.valid;
    assign RegWriteE  = r_e.reg_write;
    assign MemWriteE  = r_e.mem_write;
    assign MemReadE   = r_e.mem_read;
    assign ALUsrcE    = r_e.alu_src;
    assign ALUctrlE   = r_e.alu_ctrl;
    assign PCsrcE     = r_e.pc_src;
    assign ResultSrcE = r_e.result_src;
    assign rdE        = REG_ADDR_WIDTH'(r_e.rd);
    assign MulDivE    = r_e.muldiv;
    assign MulDivOpE  = r_e.muldiv_op;
    assign ill_count  = r_ill_count;

endmodule
`default_nettype wire

// File: tb/tb_decode_ctrl_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_decode_ctrl_pipe : directed vectors with a per-cycle expectation queue.
// Revision            : 1.0
// ---------------------------------------------------------------------------
module tb_decode_ctrl_pipe;

    typedef struct packed {
        logic       v;
        logic       rw;
        logic       mw;
        logic       mr;
        logic       as;
        logic [3:0] alu;
        logic [2:0] pc;
        logic [1:0] rs;
        logic [4:0] rd;
        logic       md;
        logic [2:0] mop;
    } e_t;

    typedef struct {
        logic       stall;
        logic       ill;
        logic [2:0] imm;
        e_t         e;
        logic [7:0] cnt;
        int         id;
    } exp_t;

    localparam e_t BUB   = '0;
    localparam e_t LW5   = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0,  3'd0, 2'd1, 5'd5,  1'b0, 3'd0};
    localparam e_t LW0   = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0,  3'd0, 2'd1, 5'd0,  1'b0, 3'd0};
    localparam e_t ADD6  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  3'd0, 2'd0, 5'd6,  1'b0, 3'd0};
    localparam e_t SW    = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  3'd0, 2'd0, 5'd0,  1'b0, 3'd0};
    localparam e_t BEQ   = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1,  3'd3, 2'd0, 5'd0,  1'b0, 3'd0};
    localparam e_t LUI10 = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd10, 3'd0, 2'd0, 5'd10, 1'b0, 3'd0};
    localparam e_t JAL1  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  3'd1, 2'd2, 5'd1,  1'b0, 3'd0};
`ifdef DECODE_CTRL_PIPE_MULDIV_EN
    localparam e_t MUL7  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  3'd0, 2'd0, 5'd7,  1'b1, 3'd0};
`endif

    localparam logic [31:0] I_LW5  = 32'h0000A283;
    localparam logic [31:0] I_LW0  = 32'h0000A003;
    localparam logic [31:0] I_ADD5 = 32'h00228333;
    localparam logic [31:0] I_ADD0 = 32'h00200333;
    localparam logic [31:0] I_SW   = 32'h0050A223;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_LUI  = 32'h12345537;
    localparam logic [31:0] I_JAL  = 32'h010000EF;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;
    localparam logic [31:0] I_MUL  = 32'h022083B3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        validD, flush, ext_stall;
    logic [2:0]  ImmSrcD;
    logic        stallD, validE, RegWriteE, MemWriteE, MemReadE, ALUsrcE;
    logic [3:0]  ALUctrlE;
    logic [2:0]  PCsrcE;
    logic [1:0]  ResultSrcE;
    logic [4:0]  rdE;
    logic        MulDivE;
    logic [2:0]  MulDivOpE;
    logic        illegalD;
    logic [7:0]  ill_count;
    e_t          act_e;

    int   n_vec  = 0;
    int   n_bad  = 0;
    int   vec_id = 0;
    exp_t sb[$];
    logic [7:0] cur;

    always #5 clk = ~clk;

    decode_ctrl_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .validD     (validD),
        .flush      (flush),
        .ext_stall  (ext_stall),
        .ImmSrcD    (ImmSrcD),
        .stallD     (stallD),
        .validE     (validE),
        .RegWriteE  (RegWriteE),
        .MemWriteE  (MemWriteE),
        .MemReadE   (MemReadE),
        .ALUsrcE    (ALUsrcE),
        .ALUctrlE   (ALUctrlE),
        .PCsrcE     (PCsrcE),
        .ResultSrcE (ResultSrcE),
        .rdE        (rdE),
        .MulDivE    (MulDivE),
        .MulDivOpE  (MulDivOpE),
        .illegalD   (illegalD),
        .ill_count  (ill_count)
    );

    assign act_e = {validE, RegWriteE, MemWriteE, MemReadE, ALUsrcE, ALUctrlE,
                    PCsrcE, ResultSrcE, rdE, MulDivE, MulDivOpE};

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, id, act, exp);
        end
    endtask

    // One call = one clock cycle: drive inputs and queue what the DUT should show this cycle.
    task automatic step(input logic [31:0] ins, input logic vd, input logic fl, input logic xs,
                        input logic es, input logic ei, input logic [2:0] eimm,
                        input e_t ee, input logic [7:0] ec);
        exp_t x;
        @(posedge clk);
        #1;
        instr     = ins;
        validD    = vd;
        flush     = fl;
        ext_stall = xs;
        x.stall = es;
        x.ill   = ei;
        x.imm   = eimm;
        x.e     = ee;
        x.cnt   = ec;
        x.id    = vec_id;
        sb.push_back(x);
        vec_id++;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                x = sb.pop_front();
                chk("stallD",    x.id, 32'(stallD),    32'(x.stall));
                chk("illegalD",  x.id, 32'(illegalD),  32'(x.ill));
                chk("ImmSrcD",   x.id, 32'(ImmSrcD),   32'(x.imm));
                chk("E_bundle",  x.id, 32'(act_e),     32'(x.e));
                chk("ill_count", x.id, 32'(ill_count), 32'(x.cnt));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, pending %0d expected 0", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_n = 1'b0; instr = '0; validD = 1'b0; flush = 1'b0; ext_stall = 1'b0;
        @(negedge clk);
        chk("reset_E",   -1, 32'(act_e),     32'(BUB));
        chk("reset_cnt", -1, 32'(ill_count), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Load-use hazard, non-dependent consumer, rd=x0 load
        step(I_LW5,  1, 0, 0,  0, 0, 3'd0, BUB,  8'd0);
        step(I_ADD5, 1, 0, 0,  1, 0, 3'd0, LW5,  8'd0);
        step(I_ADD5, 1, 0, 0,  0, 0, 3'd0, BUB,  8'd0);
        step(I_LW5,  1, 0, 0,  0, 0, 3'd0, ADD6, 8'd0);
        step(I_ADD0, 1, 0, 0,  0, 0, 3'd0, LW5,  8'd0);
        step(I_LW0,  1, 0, 0,  0, 0, 3'd0, ADD6, 8'd0);
        step(I_ADD0, 1, 0, 0,  0, 0, 3'd0, LW0,  8'd0);
        // Flush beats a pending load-use stall
        step(I_LW5,  1, 0, 0,  0, 0, 3'd0, ADD6, 8'd0);
        step(I_ADD5, 1, 1, 0,  0, 0, 3'd0, LW5,  8'd0);
        // Other formats; ext_stall freezes E for three cycles
        step(I_SW,   1, 0, 0,  0, 0, 3'd1, BUB,  8'd0);
        step(I_BEQ,  1, 0, 0,  0, 0, 3'd2, SW,   8'd0);
        step(I_LUI,  1, 0, 1,  0, 0, 3'd3, BEQ,  8'd0);
        step(I_LUI,  1, 0, 1,  0, 0, 3'd3, BEQ,  8'd0);
        step(I_LUI,  1, 0, 1,  0, 0, 3'd3, BEQ,  8'd0);
        step(I_LUI,  1, 0, 0,  0, 0, 3'd3, BEQ,  8'd0);
        step(I_JAL,  1, 0, 0,  0, 0, 3'd4, LUI10, 8'd0);
        // Illegal instructions and the counter gating
        step(I_BAD,  1, 0, 0,  0, 1, 3'd0, JAL1, 8'd0);
        step(I_BAD,  1, 0, 0,  0, 1, 3'd0, BUB,  8'd1);
        step(I_BAD,  1, 0, 0,  0, 1, 3'd0, BUB,  8'd2);
        step(32'h0,  0, 0, 0,  0, 0, 3'd0, BUB,  8'd3);
        step(I_BAD,  1, 0, 1,  0, 1, 3'd0, BUB,  8'd3);
        step(I_BAD,  1, 1, 0,  0, 1, 3'd0, BUB,  8'd3);
        // Load-use stall stretched by ext_stall
        step(I_LW5,  1, 0, 0,  0, 0, 3'd0, BUB,  8'd3);
        step(I_ADD5, 1, 0, 1,  1, 0, 3'd0, LW5,  8'd3);
        step(I_ADD5, 1, 0, 0,  1, 0, 3'd0, LW5,  8'd3);
        step(I_ADD5, 1, 0, 0,  0, 0, 3'd0, BUB,  8'd3);
        step(32'h0,  0, 0, 0,  0, 0, 3'd0, ADD6, 8'd3);
`ifdef DECODE_CTRL_PIPE_MULDIV_EN
        step(I_MUL,  1, 0, 0,  1, 0, 3'd0, BUB,  8'd3);
        step(I_MUL,  1, 0, 0,  1, 0, 3'd0, BUB,  8'd3);
        step(I_MUL,  1, 0, 0,  1, 0, 3'd0, BUB,  8'd3);
        step(I_MUL,  1, 0, 0,  1, 0, 3'd0, BUB,  8'd3);
        step(I_MUL,  1, 0, 0,  0, 0, 3'd0, BUB,  8'd3);
        step(32'h0,  0, 0, 0,  0, 0, 3'd0, MUL7, 8'd3);
        cur = 8'd3;
`else
        step(I_MUL,  1, 0, 0,  0, 1, 3'd0, BUB,  8'd3);
        step(32'h0,  0, 0, 0,  0, 0, 3'd0, BUB,  8'd4);
        cur = 8'd4;
`endif
        // Drive the counter into saturation
        for (int i = 0; i < 260; i++) begin
            step(I_BAD, 1, 0, 0,  0, 1, 3'd0, BUB, cur);
            cur = (cur == 8'hFF) ? 8'hFF : cur + 8'd1;
        end
        step(32'h0,  0, 0, 0,  0, 0, 3'd0, BUB,  8'hFF);

        // Park a load in E, then assert reset mid-cycle
        step(I_LW5,  1, 0, 0,  0, 0, 3'd0, BUB,  8'hFF);
        step(32'h0,  0, 0, 1,  0, 0, 3'd0, LW5,  8'hFF);
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        chk("queue_drain", -1, 32'(sb.size()), 32'd0);
        @(posedge clk);
        #3;
        chk("pre_reset_validE", -1, 32'(validE), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_E",   -1, 32'(act_e),     32'(BUB));
        chk("async_reset_cnt", -1, 32'(ill_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        ext_stall = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_ctrl_pipe.md
Name: decode_ctrl_pipe

Overview:
Registered successor to the combinational RV32I control decoder. It decodes the D-stage instruction and drives immediate-select combinationally, and holds the ID/EX control bundle in a register. It detects load-use hazards and handles flush and external hold. Optionally it decodes RV32M and sequences a fixed-latency mul/div issue stall. It sits between the IF/ID register and the execute stage.

Parameters:
- DATA_WIDTH, 32, instruction width; must be 32.
- REG_ADDR_WIDTH, 5, register index width.
- MULDIV_LATENCY, 4, extra D-stage stall cycles for an M op; must be ≥1.
- ILL_CNT_WIDTH, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- instr  in  DATA_WIDTH  D-stage instruction.
- validD  in  1  instr is a real instruction.
- flush  in  1  kill D and E contents (taken branch or jump).
- ext_stall  in  1  downstream hold; freezes all state.
- ImmSrcD  out  3  combinational immediate select (SIGN_EXTEND_* codes).
- stallD  out  1  hold PC and IF/ID this cycle.
- validE  out  1  E-stage slot holds an instruction.
- RegWriteE, MemWriteE, MemReadE, ALUsrcE  out  1 each  registered controls.
- ALUctrlE  out  4  registered ALU_OPCODE_*.
- PCsrcE  out  3  registered PC_* code.
- ResultSrcE  out  2  registered result select.
- rdE  out  REG_ADDR_WIDTH  registered destination register.
- MulDivE  out  1  E-stage op is RV32M.
- MulDivOpE  out  3  funct3 of the M op.
- illegalD  out  1  combinational: valid instr with an undecodable opcode/funct.
- ill_count  out  ILL_CNT_WIDTH  saturating count of illegal instructions consumed.

Behaviour:
- Decode table: identical to the RV32I control unit (R, I, load, store, branch, jal, jalr, lui, auipc, system). Undefined funct or opcode sets illegalD=1 and decodes to a bubble.
- Bubble definition: validE=0, RegWriteE=MemWriteE=MemReadE=MulDivE=0, PCsrcE=PC_NEXT, ALUctrlE=ALU_OPCODE_ADD, all other fields 0.
- Reset: every registered output takes bubble values; rdE=0, MulDivOpE=0, ill_count=0, FSM=IDLE. Reset mid-operation discards any pending M op.
- Register update priority each rising edge:
  1. flush: E←bubble, FSM→IDLE, counter reloaded.
  2. ext_stall: all registers hold (flush still wins).
  3. stallD=1: E←bubble.
  4. Otherwise: E←decode(instr) if validD, else E←bubble.
- Load-use hazard: stallD=1 when validE & MemReadE & rdE≠0 & validD & rdE matches a source register that instr actually reads. rs1 is read by R/I/load/store/branch/jalr; rs2 by R/store/branch. The stall lasts exactly one cycle unless ext_stall extends it.
- stallD = load-use | muldiv_busy; forced 0 while flush=1.
- ill_count increments by 1 when illegalD & validD & ~stallD & ~ext_stall & ~flush. It saturates at all-ones.
- Latency: a decoded instruction appears on the E outputs 1 cycle after acceptance.

Optional Feature:
- Macro: DECODE_CTRL_PIPE_MULDIV_EN.
- Defined:
  - R-type with funct7=0x01 is an M op.
  - FSM: IDLE→BUSY on the first cycle an M op is valid in D (not flushed, not ext_stall). It loads count=MULDIV_LATENCY-1 and asserts stallD.
  - In BUSY: stallD=1 and count decrements; at count==0, stallD=0, the op enters E with MulDivE=1, MulDivOpE=funct3, RegWriteE=1, and the FSM→IDLE.
  - Total D residency is MULDIV_LATENCY+1 cycles.
- Undefined: funct7=0x01 is illegal, MulDivE/MulDivOpE are tied 0, and the FSM is absent.

Decomposition:
- Shared package decode_pkg: ALU_OPCODE_*, PC_*, SIGN_EXTEND_*, opcode constants, a ctrl_bundle_t struct, and a muldiv_state_t enum.
- One sub-module, decode_comb: the pure combinational decode table (instr → ctrl_bundle_t, illegal, uses_rs1, uses_rs2).
- This module owns the ID/EX register, hazard logic, FSM and counter.

Test Plan:
- Reset with rst_n=0 asynchronously mid-cycle → all E outputs are bubble and ill_count=0 immediately, before the next edge.
- lw x5,0(x1) (0x0000A283) then add x6,x5,x2 (0x00228333) → stallD=1 for one cycle and E shows a bubble; the add enters E next with rdE=6, RegWriteE=1, ALUctrlE=ADD.
- Same lw followed by add x6,x0,x2 (0x00200333) → no stall; an lw with rd=x0 followed by a consumer → no stall.
- flush=1 concurrent with a load-use hazard → stallD=0, E←bubble next edge; ext_stall=1 for 3 cycles → E fields are unchanged throughout.
- Three consecutive 0xFFFFFFFF with validD=1 → illegalD=1 and E bubbles; ill_count goes 0→3. Preloaded at 255 → it stays at 255.
- With the macro and MULDIV_LATENCY=4, mul x7,x1,x2 (0x022083B3) → stallD high for 4 cycles, then MulDivE=1, MulDivOpE=0, rdE=7. Without the macro → illegalD=1 and a bubble.
